// File: rtl/imem_loader_if.sv
// Pin-side and imem-side signal bundle for imem_loader.
// The slave modport is the loader's view; the master modport drives the pins and watches the outputs.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic              load_req;
    logic              start;
    logic [7:0]        data_in;
    logic              data_stb;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              core_run;
    logic              busy;
    logic              err;

    modport master (
        output load_req, start, data_in, data_stb,
        input  wr_en, wr_addr, wr_data, core_run, busy, err
    );

    modport slave (
        input  load_req, start, data_in, data_stb,
        output wr_en, wr_addr, wr_data, core_run, busy, err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: synchronises an asynchronous byte strobe and streams bytes into imem.
// Optional trailer checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_SZ     = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = RUN;
`endif

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

    state_t                 state_r;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   stb_prev_r;
    logic                   edge_s;
    logic [ADDR_W-1:0]      addr_r;
    logic                   last_s;
    logic                   write_s;
    logic                   enter_load_s;
    logic                   wr_en_r;
    logic [ADDR_W-1:0]      wr_addr_r;
    logic [7:0]             wr_data_r;
    logic                   core_run_r;
    logic                   busy_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum_r;
    logic                   err_r;
    logic                   fail_s;
`endif

    assign edge_s = sync_r[SYNC_STAGES-1] & ~stb_prev_r;
    assign last_s = (addr_r == ADDR_W'(IMEM_SZ - 1));

    // Next-state and write decision; abort on load_req low takes priority over a strobe edge.
    always_comb begin
        state_n      = state_r;
        write_s      = 1'b0;
        enter_load_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        fail_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.load_req) begin
                    state_n      = LOAD;
                    enter_load_s = 1'b1;
                end else if (bus.start) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                if (!bus.load_req) begin
                    state_n = IDLE;
                end else if (edge_s) begin
                    write_s = 1'b1;
                    if (last_s) begin
                        state_n = AFTER_LOAD;
                    end else begin
                        state_n = LOAD;
                    end
                end else begin
                    state_n = LOAD;
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (!bus.load_req) begin
                    state_n = IDLE;
                end else if (edge_s) begin
                    if (bus.data_in == csum_r) begin
                        state_n = RUN;
                    end else begin
                        state_n = IDLE;
                        fail_s  = 1'b1;
                    end
                end else begin
                    state_n = CHECK;
                end
`else
                state_n = IDLE;
`endif
            end
            RUN: begin
                if (bus.load_req) begin
                    state_n      = LOAD;
                    enter_load_s = 1'b1;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, strobe synchroniser, address counter and registered imem/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sync_r     <= '0;
            stb_prev_r <= 1'b0;
            addr_r     <= '0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= '0;
            wr_data_r  <= 8'h00;
            core_run_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            sync_r     <= {sync_r[SYNC_STAGES-2:0], bus.data_stb};
            stb_prev_r <= sync_r[SYNC_STAGES-1];
            wr_en_r    <= write_s;
            core_run_r <= (state_n == RUN);
            busy_r     <= (state_n == LOAD) || (state_n == CHECK);
            // The address parks on the last slot rather than wrapping past IMEM_SZ-1.
            if (enter_load_s) begin
                addr_r <= '0;
            end else if (write_s && !last_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= addr_r;
            end
            if (write_s) begin
                wr_addr_r <= addr_r;
                wr_data_r <= bus.data_in;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of written bytes and sticky trailer-mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= 8'h00;
            err_r  <= 1'b0;
        end else if (enter_load_s) begin
            csum_r <= 8'h00;
            err_r  <= 1'b0;
        end else if (write_s) begin
            csum_r <= csum_next(csum_r, bus.data_in);
        end else if (fail_s) begin
            err_r <= 1'b1;
        end else begin
            csum_r <= csum_r;
            err_r  <= err_r;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.core_run = core_run_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [7:0] pat [16] = '{8'h5B, 8'h07, 8'hC3, 8'hA1, 8'h3C, 8'h96, 8'hE4, 8'h12,
                             8'h7F, 8'h80, 8'h2D, 8'hD5, 8'h68, 8'hB9, 8'h4E, 8'h00};

    imem_loader_if #(.ADDR_W(4)) bus ();

    imem_loader #(.IMEM_SZ(16), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One strobe; the write (if any) must appear exactly three cycles after the rising edge.
    task automatic send_byte(input logic [7:0] d, input bit exp_wr, input logic [3:0] exp_addr,
                             input bit release_req, input string tag);
        @(negedge clk);
        bus.data_in  = d;
        bus.data_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check_eq({tag, "_early"}, 32'(bus.wr_en), 32'd0);
        @(posedge clk);
        #1 check_eq({tag, "_wr_en"}, 32'(bus.wr_en), 32'(exp_wr));
        if (exp_wr) begin
            check_eq({tag, "_addr"}, 32'(bus.wr_addr), 32'(exp_addr));
            check_eq({tag, "_data"}, 32'(bus.wr_data), 32'(d));
        end
        if (release_req) bus.load_req = 1'b0;
        @(negedge clk);
        bus.data_stb = 1'b0;
        @(posedge clk);
        #1 check_eq({tag, "_pulse_end"}, 32'(bus.wr_en), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [7:0] trailer;
        bus.load_req = 1'b0;
        bus.start    = 1'b0;
        bus.data_in  = 8'h00;
        bus.data_stb = 1'b0;

        // Reset held two cycles: every output low.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check_eq("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check_eq("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check_eq("rst_core_run", 32'(bus.core_run), 32'd0);
        check_eq("rst_busy",     32'(bus.busy),     32'd0);
        check_eq("rst_err",      32'(bus.err),      32'd0);

        // load_req and start together in IDLE: LOAD wins.
        @(negedge clk);
        rst          = 1'b0;
        bus.load_req = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        check_eq("both_busy",     32'(bus.busy),     32'd1);
        check_eq("both_core_run", 32'(bus.core_run), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;

        // Full 16-byte program.
        trailer = 8'h00;
        for (int i = 0; i < 16; i++) begin
            trailer = trailer ^ pat[i];
            send_byte(pat[i], 1'b1, 4'(i), (i == 15) && !CK, $sformatf("load%0d", i));
        end
        if (CK) begin
            check_eq("pre_check_busy", 32'(bus.busy), 32'd1);
            send_byte(trailer, 1'b0, 4'd0, 1'b1, "trailer_ok");
        end
        check_eq("load_done_run",  32'(bus.core_run), 32'd1);
        check_eq("load_done_busy", 32'(bus.busy),     32'd0);
        check_eq("load_done_err",  32'(bus.err),      32'd0);

        // In RUN: start ignored, strobes discarded.
        @(negedge clk);
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_eq("run_start_ignored", 32'(bus.core_run), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'hAA, 1'b0, 4'd0, 1'b0, "run_stb");
        check_eq("run_stb_addr_hold", 32'(bus.wr_addr), 32'd15);

        // Back to LOAD: first write lands at address 0.
        @(negedge clk);
        bus.load_req = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reload_busy",     32'(bus.busy),     32'd1);
        check_eq("reload_core_run", 32'(bus.core_run), 32'd0);
        send_byte(8'h11, 1'b1, 4'd0, 1'b0, "reload0");
        send_byte(8'h22, 1'b1, 4'd1, 1'b0, "reload1");
        send_byte(8'h33, 1'b1, 4'd2, 1'b0, "reload2");
        send_byte(8'h44, 1'b1, 4'd3, 1'b0, "reload3");
        send_byte(8'h55, 1'b1, 4'd4, 1'b0, "reload4");

        // Abort after five bytes: no further writes, outputs hold.
        @(negedge clk);
        bus.load_req = 1'b0;
        @(posedge clk);
        #1 check_eq("abort_busy", 32'(bus.busy), 32'd0);
        send_byte(8'h66, 1'b0, 4'd0, 1'b0, "after_abort");
        check_eq("abort_addr_hold", 32'(bus.wr_addr), 32'd4);
        check_eq("abort_data_hold", 32'(bus.wr_data), 32'h55);

        // Reassert: restart at address 0.
        @(negedge clk);
        bus.load_req = 1'b1;
        @(posedge clk);
        send_byte(8'h77, 1'b1, 4'd0, 1'b0, "restart0");

        // Abort in the same cycle as a detected edge: abort wins.
        @(negedge clk);
        bus.data_in  = 8'h88;
        bus.data_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.load_req = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_edge_wr_en", 32'(bus.wr_en),   32'd0);
        check_eq("abort_edge_busy",  32'(bus.busy),    32'd0);
        check_eq("abort_edge_addr",  32'(bus.wr_addr), 32'd0);
        check_eq("abort_edge_data",  32'(bus.wr_data), 32'h77);
        @(negedge clk);
        bus.data_stb = 1'b0;
        repeat (3) @(posedge clk);

        // Reset lands on the edge a write would have occurred.
        @(negedge clk);
        bus.load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_in  = 8'h99;
        bus.data_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_wr_en", 32'(bus.wr_en),   32'd0);
        check_eq("rst_mid_busy",  32'(bus.busy),    32'd0);
        check_eq("rst_mid_addr",  32'(bus.wr_addr), 32'd0);
        check_eq("rst_mid_data",  32'(bus.wr_data), 32'd0);
        @(negedge clk);
        bus.data_stb = 1'b0;
        bus.load_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("post_rst_idle", 32'(bus.wr_en), 32'd0);

        if (CK) begin
            // Sixteen 0x01 bytes XOR to 0x00: correct trailer reaches RUN.
            @(negedge clk);
            bus.load_req = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 16; i++) send_byte(8'h01, 1'b1, 4'(i), 1'b0, $sformatf("ones%0d", i));
            send_byte(8'h00, 1'b0, 4'd0, 1'b1, "trailer_pass");
            check_eq("ck_pass_run", 32'(bus.core_run), 32'd1);
            check_eq("ck_pass_err", 32'(bus.err),      32'd0);

            // Wrong trailer: back to IDLE with err set.
            @(negedge clk);
            bus.load_req = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 16; i++) send_byte(8'h01, 1'b1, 4'(i), 1'b0, $sformatf("ones_b%0d", i));
            send_byte(8'h01, 1'b0, 4'd0, 1'b1, "trailer_fail");
            check_eq("ck_fail_run",  32'(bus.core_run), 32'd0);
            check_eq("ck_fail_busy", 32'(bus.busy),     32'd0);
            check_eq("ck_fail_err",  32'(bus.err),      32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
